// File: rtl/muldiv_iter_if.sv
// Request/result bundle between the E stage and the iterative multiply/divide unit.
// The E stage drives the master side; the unit is the slave.
interface muldiv_iter_if #(
    parameter int WIDTH = 32
);
    logic             start_i;
    logic [1:0]       op_i;
    logic [WIDTH-1:0] a_i;
    logic [WIDTH-1:0] b_i;
    logic             flush_i;
    logic             hilo_we_i;
    logic             hilo_sel_i;
    logic [WIDTH-1:0] wdata_i;
    logic             busy_o;
    logic             done_o;
    logic             div0_o;
    logic [WIDTH-1:0] hi_o;
    logic [WIDTH-1:0] lo_o;

    modport master (
        output start_i, op_i, a_i, b_i, flush_i, hilo_we_i, hilo_sel_i, wdata_i,
        input  busy_o, done_o, div0_o, hi_o, lo_o
    );

    modport slave (
        input  start_i, op_i, a_i, b_i, flush_i, hilo_we_i, hilo_sel_i, wdata_i,
        output busy_o, done_o, div0_o, hi_o, lo_o
    );
endinterface

// File: rtl/muldiv_iter.sv
// Iterative MIPS multiply/divide unit owning HI/LO: one radix-2 step per cycle on operand
// magnitudes, sign correction in a final FIX cycle. Latency is WIDTH+1 cycles.
module muldiv_iter #(
    parameter int WIDTH = 32
) (
    input logic          clk,
    input logic          reset,
    muldiv_iter_if.slave bus
);
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

    state_t           state;
    logic             busy;
    logic             done;
    logic             div0;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    logic             is_div;
    logic             neg_res;
    logic             neg_rem;
    logic             div0_pend;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] mcand;
    logic [WIDTH-1:0] upper;
    logic [WIDTH-1:0] lower;

    logic               accept;
    logic               signed_op;
    logic               div_ge;
    logic [WIDTH-1:0]   a_mag;
    logic [WIDTH-1:0]   b_mag;
    logic [WIDTH-1:0]   div_sub;
    logic [WIDTH-1:0]   quo_fix;
    logic [WIDTH-1:0]   rem_fix;
    logic [WIDTH:0]     mul_sum;
    logic [WIDTH:0]     div_shift;
    logic [2*WIDTH-1:0] prod_fix;

    // NOTE: every signal here is assigned on every pass, so no latch can be inferred.
    always_comb begin
        accept    = (state == IDLE) && bus.start_i && !bus.flush_i;
        signed_op = !bus.op_i[0];
        a_mag     = (signed_op && bus.a_i[WIDTH-1]) ? -bus.a_i : bus.a_i;
        b_mag     = (signed_op && bus.b_i[WIDTH-1]) ? -bus.b_i : bus.b_i;
        // upper:lower is the product accumulator when multiplying and remainder:quotient when dividing
        mul_sum   = {1'b0, upper} + (lower[0] ? {1'b0, mcand} : '0);
        div_shift = {upper, lower[WIDTH-1]};
        div_ge    = div_shift >= {1'b0, mcand};
        div_sub   = div_shift[WIDTH-1:0] - mcand;
        prod_fix  = neg_res ? -{upper, lower} : {upper, lower};
        // A zero divisor leaves the dividend magnitude as remainder, so HI comes out as raw a
        quo_fix   = div0_pend ? '1 : (neg_res ? -lower : lower);
        rem_fix   = neg_rem ? -upper : upper;
    end

    // NOTE: the datapath has no reset; every operation reloads it on the accepting edge.
    always_ff @(posedge clk) begin
        if (accept) begin
            is_div    <= bus.op_i[1];
            neg_res   <= signed_op && (bus.a_i[WIDTH-1] ^ bus.b_i[WIDTH-1]);
            neg_rem   <= signed_op && bus.a_i[WIDTH-1];
            div0_pend <= bus.op_i[1] && (bus.b_i == '0);
            mcand     <= bus.op_i[1] ? b_mag : a_mag;
            lower     <= bus.op_i[1] ? a_mag : b_mag;
            upper     <= '0;
            cnt       <= CW'(WIDTH);
        end else if (state == RUN) begin
            cnt <= cnt - CW'(1);
            if (is_div) begin
                upper <= div_ge ? div_sub : div_shift[WIDTH-1:0];
                lower <= {lower[WIDTH-2:0], div_ge};
            end else begin
                upper <= mul_sum[WIDTH:1];
                lower <= {mul_sum[0], lower[WIDTH-1:1]};
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
            div0  <= 1'b0;
            hi    <= '0;
            lo    <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        state <= RUN;
                        busy  <= 1'b1;
                        div0  <= 1'b0;
                    end else if (bus.hilo_we_i) begin
                        if (bus.hilo_sel_i) hi <= bus.wdata_i;
                        else                lo <= bus.wdata_i;
                    end
                end
                RUN: begin
                    if (bus.flush_i) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else if (cnt == CW'(1)) begin
                        state <= FIX;
                    end
                end
                FIX: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    if (!bus.flush_i) begin
                        done <= 1'b1;
                        div0 <= div0_pend;
                        if (is_div) begin
                            hi <= rem_fix;
                            lo <= quo_fix;
                        end else begin
                            {hi, lo} <= prod_fix;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.busy_o = busy;
    assign bus.done_o = done;
    assign bus.div0_o = div0;
    assign bus.hi_o   = hi;
    assign bus.lo_o   = lo;
endmodule

// File: doc/muldiv_iter.md
# muldiv_iter

Parametrised iterative multiply/divide unit holding the HI/LO register pair for the MIPS core. It executes in the E stage and raises `busy_o` while an operation runs, which the hazard unit uses as the mult/div-running stall. It extends the fixed 32-bit unit with:
- a configurable operand width,
- a flush/abort input,
- a defined divide-by-zero result with a status flag,
- a defined signed-overflow result.

## Interface
- `WIDTH`, 32, operand and HI/LO width (≥4, even)
- `clk`  in  1  clock, all state changes on rising edge
- `reset`  in  1  synchronous, active-high
- `start_i`  in  1  single-cycle request to begin an operation; sampled only in IDLE
- `op_i`  in  2  operation: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU
- `a_i`  in  WIDTH  multiplicand / dividend, sampled with `start_i`
- `b_i`  in  WIDTH  multiplier / divisor, sampled with `start_i`
- `flush_i`  in  1  abort the running operation (E-stage flush)
- `hilo_we_i`  in  1  direct write, for MTHI/MTLO
- `hilo_sel_i`  in  1  target of the direct write: 1 HI, 0 LO
- `wdata_i`  in  WIDTH  direct write data
- `busy_o`  out  1  operation in progress
- `done_o`  out  1  one-cycle pulse: HI/LO were updated by a completed operation
- `div0_o`  out  1  last completed operation was a divide by zero; held until the next accepted start
- `hi_o`  out  WIDTH  HI register
- `lo_o`  out  WIDTH  LO register

## Operation
- **States:** IDLE, RUN, FIX.
- **IDLE to RUN:** when `start_i`=1 and `flush_i`=0. At that edge the unit latches:
  - the op,
  - the operand magnitudes (absolute value for MULT/DIV, raw value for the unsigned ops),
  - the result sign bits,
  - iteration counter = WIDTH.
- **RUN, multiply:** one radix-2 shift-add step per cycle into a 2·WIDTH accumulator.
- **RUN, divide:** one restoring-division step per cycle (partial remainder of WIDTH+1 bits).
- **RUN to FIX:** the counter decrements each RUN cycle; the transition happens on the edge where the counter reaches 0.
- **FIX:** applies the sign correction, writes HI/LO, pulses `done_o`, returns to IDLE.
- **Sign rules:**
  - product is negated (2·WIDTH two's complement) if the operand signs differ;
  - quotient is negated if the signs differ;
  - remainder takes the sign of the dividend.
- **Result placement:**
  - MULT/MULTU: HI = upper WIDTH bits of the product, LO = lower WIDTH bits.
  - DIV/DIVU: LO = quotient, HI = remainder.
- **Divide by zero (b=0, DIV or DIVU):** normal latency; result is LO = all ones, HI = raw `a_i`; `div0_o`=1 from the FIX edge.
- **Signed overflow (DIV with a = −2^(WIDTH−1), b = −1):** LO = −2^(WIDTH−1), HI = 0; no flag.
- **`start_i` while busy:** ignored.
- **`start_i` and `hilo_we_i` in the same IDLE cycle:** start wins; the write is dropped.
- **`hilo_we_i` while busy:** ignored, so HI/LO are never changed mid-operation.
- **`hilo_we_i` in IDLE alone:** writes `wdata_i` to the selected register at the next edge; `done_o` stays 0.
- **`flush_i`=1 in RUN or FIX:**
  - state goes to IDLE at the next edge;
  - HI/LO and `div0_o` keep their prior values;
  - no `done_o`.
- **`flush_i`=1 in IDLE:** any `start_i` that cycle is ignored.
- **`reset`** (any state, including mid-operation): at the next edge the state goes to IDLE, HI/LO clear to 0, and `busy_o`, `done_o`, `div0_o` clear to 0.

## Timing
- **Reset values:** `busy_o`=0, `done_o`=0, `div0_o`=0, `hi_o`=0, `lo_o`=0.
- **Start edge t (start accepted):**
  - `busy_o`=1 from after edge t until edge t+WIDTH+1;
  - RUN covers edges t+1 … t+WIDTH;
  - FIX is at edge t+WIDTH+1.
- **After edge t+WIDTH+1:**
  - `hi_o`/`lo_o` hold the result;
  - `done_o`=1 for exactly one cycle;
  - `busy_o`=0.
  - Total latency is WIDTH+1 cycles; for WIDTH=32 that is 33.
- **Back-to-back:** a new start is accepted in the cycle `done_o`=1, since the state is IDLE.
- **Direct write:** one-cycle latency; the value is visible on `hi_o`/`lo_o` after the edge.
- **Registers:** all outputs are registered; there is no combinational path from inputs to outputs.

## Test plan
- **MULTU, WIDTH=32:** a=b=0xFFFFFFFF → after 33 cycles HI=0xFFFFFFFE, LO=0x00000001; `done_o` pulses once; `busy_o` is high for 33 cycles.
- **MULT:** a=−3, b=5 → HI=0xFFFFFFFF, LO=0xFFFFFFF1.
- **DIV:** a=−7, b=2 → LO=0xFFFFFFFD, HI=0xFFFFFFFF.
- **DIV overflow:** a=0x80000000, b=−1 → LO=0x80000000, HI=0, `div0_o`=0.
- **DIVU by zero:** a=0x1234, b=0 → LO=0xFFFFFFFF, HI=0x1234, `div0_o`=1. The next start then clears `div0_o`.
- **Abort and hazards:**
  - preload HI/LO via direct writes to 0xAAAA/0x5555;
  - start MULTU; at cycle 10 assert `flush_i` → state is IDLE next cycle, HI/LO unchanged, no `done_o`;
  - repeat with `hilo_we_i` mid-operation (write ignored) and with `reset` mid-operation (all cleared).
  - Rerun the arithmetic cases with WIDTH=8: latency is 9 cycles and results match the 8-bit reference.
